// File: rtl/rat_int_pkg.sv
// Shared types and constants for the rat_int_ctrl interrupt controller:
// FSM state encoding, source count, default I/O port map and hold timing.
package rat_int_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  localparam logic [7:0] MASK_ADDR_DEF = 8'hF0;
  localparam logic [7:0] ACK_ADDR_DEF  = 8'hF1;
  localparam logic [7:0] ID_ADDR_DEF   = 8'hF2;
  localparam logic [7:0] PEND_ADDR_DEF = 8'hF3;

  localparam int              HOLD_W   = 2;
  localparam logic [HOLD_W-1:0] HOLD_CNT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Fixed priority: lowest set index wins.
  function automatic logic [ID_W-1:0] prio_idx(input logic [N_SRC-1:0] v);
    prio_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) prio_idx = ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector.
// rise[i] is a one-cycle pulse, combinational from the synchronized history.
module int_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] hist_q, hist_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q & ~hist_q;

endmodule

// File: rtl/rat_int_ctrl.sv
// Eight-source fixed-priority interrupt controller with an I/O-mapped mask,
// pending, current-ID and end-of-interrupt ports; INT_CU is registered.
module rat_int_ctrl #(
  parameter int         N_SRC     = rat_int_pkg::N_SRC,
  parameter logic [7:0] MASK_ADDR = rat_int_pkg::MASK_ADDR_DEF,
  parameter logic [7:0] ACK_ADDR  = rat_int_pkg::ACK_ADDR_DEF,
  parameter logic [7:0] ID_ADDR   = rat_int_pkg::ID_ADDR_DEF,
  parameter logic [7:0] PEND_ADDR = rat_int_pkg::PEND_ADDR_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic             INT_CU,
  output logic [7:0]       IN_DATA,
  output logic             IN_SEL
);

  import rat_int_pkg::*;

  logic [N_SRC-1:0]  irq_rise;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  active;
  logic [N_SRC-1:0]  ack_clr;
  logic              mask_wr;
  logic              ack_wr;

  state_e            state_q;
  logic [ID_W-1:0]   cur_id_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              int_cu_q;

  int_sync_edge #(.W(N_SRC)) u_sync_edge (
    .clk      (CLK),
    .rst      (RESET),
    .async_in (IRQ),
    .rise     (irq_rise)
  );

  assign mask_wr = IO_STRB && (PORT_ID == MASK_ADDR);
  // End-of-interrupt only means something while a request is outstanding.
  assign ack_wr  = IO_STRB && (PORT_ID == ACK_ADDR) && (state_q == REQ);
  assign active  = pend_q & mask_q;

  always_comb begin
    ack_clr = '0;
    if (ack_wr) ack_clr[cur_id_q] = 1'b1;
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_wr) mask_d = OUT_PORT[N_SRC-1:0];
  end

  // A fresh edge on the source being acknowledged outranks the clear.
  always_comb begin
    pend_d = (pend_q & ~ack_clr) | irq_rise;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      hold_cnt_q <= '0;
      int_cu_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (active != '0) begin
            cur_id_q <= prio_idx(active);
            state_q  <= REQ;
            int_cu_q <= 1'b1;
          end
        end
        REQ: begin
          if (ack_wr) begin
            hold_cnt_q <= HOLD_CNT;
            state_q    <= HOLD;
            int_cu_q   <= 1'b0;
          end
        end
        HOLD: begin
          // Leaves on the cycle the count reaches zero: three low cycles total.
          if (hold_cnt_q > HOLD_W'(1)) begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end else begin
            hold_cnt_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          int_cu_q <= 1'b0;
        end
      endcase
    end
  end

  assign INT_CU = int_cu_q;
  assign IN_SEL = (PORT_ID == MASK_ADDR) || (PORT_ID == ID_ADDR) ||
                  (PORT_ID == PEND_ADDR);

  always_comb begin
    IN_DATA = 8'h00;
    if (PORT_ID == MASK_ADDR)      IN_DATA = 8'(mask_q);
    else if (PORT_ID == PEND_ADDR) IN_DATA = 8'(pend_q);
    else if (PORT_ID == ID_ADDR)   IN_DATA = {state_q == REQ, 4'b0000, cur_id_q};
  end

  a_int_cu_only_in_req: assert property (
    @(posedge CLK) disable iff (RESET) int_cu_q == (state_q == REQ));

  a_hold_bounded: assert property (
    @(posedge CLK) disable iff (RESET) (state_q == HOLD) |-> (hold_cnt_q <= HOLD_CNT));

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Directed bench for rat_int_ctrl: hand-computed expectations for reset,
// latency, priority, masking, ACK/edge collision, stray ACK and mid-REQ reset.
module tb_rat_int_ctrl;

  localparam logic [7:0] A_MASK = 8'hF0;
  localparam logic [7:0] A_ACK  = 8'hF1;
  localparam logic [7:0] A_ID   = 8'hF2;
  localparam logic [7:0] A_PEND = 8'hF3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IRQ;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       INT_CU;
  logic [7:0] IN_DATA;
  logic       IN_SEL;

  int n_tests = 0;
  int n_fail  = 0;

  rat_int_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IRQ      (IRQ),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .INT_CU   (INT_CU),
    .IN_DATA  (IN_DATA),
    .IN_SEL   (IN_SEL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    PORT_ID  = a;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    step(1);
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    PORT_ID = a;
    #1;
    chk(tag, IN_DATA, exp);
    PORT_ID = 8'h00;
  endtask

  task automatic chk_int(input string tag, input logic exp);
    chk(tag, {7'd0, INT_CU}, {7'd0, exp});
  endtask

  initial begin
    RESET = 1'b1; IRQ = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    #2;
    chk_int("rst_int", 1'b0);
    chk_rd("rst_mask", A_MASK, 8'h00);
    chk_rd("rst_pend", A_PEND, 8'h00);
    chk_rd("rst_id",   A_ID,   8'h00);
    PORT_ID = A_ID;   #1; chk("sel_id",   {7'd0, IN_SEL}, 8'h01);
    PORT_ID = A_ACK;  #1; chk("sel_ack",  {7'd0, IN_SEL}, 8'h00);
    PORT_ID = 8'h10;  #1; chk("sel_other",{7'd0, IN_SEL}, 8'h00);
    chk_rd("rd_other", 8'h10, 8'h00);
    step(2);
    RESET = 1'b0;
    step(2);

    // Single source: IRQ[2] raised before E0 -> PEND at E2, INT_CU at E3.
    wr(A_MASK, 8'h04);
    chk_rd("mask_rb", A_MASK, 8'h04);
    IRQ = 8'h04;
    step(2);
    chk_rd("s1_pend_e1", A_PEND, 8'h00);
    step(1);
    chk_rd("s1_pend_e2", A_PEND, 8'h04);
    chk_int("s1_int_e2", 1'b0);
    step(1);
    chk_int("s1_int_e3", 1'b1);
    chk_rd("s1_id", A_ID, 8'h82);
    IRQ = 8'h00;
    wr(A_ACK, 8'h5A);
    chk_int("s1_hold0", 1'b0);
    chk_rd("s1_pend_ack", A_PEND, 8'h00);
    step(1); chk_int("s1_hold1", 1'b0);
    step(1); chk_int("s1_hold2", 1'b0);
    chk_rd("s1_id_after", A_ID, 8'h02);
    step(2);

    // Priority: IRQ[5] and IRQ[1] together, 1 serviced first, no preemption of 5.
    wr(A_MASK, 8'hFF);
    IRQ = 8'h22;
    step(3);
    chk_rd("p_pend", A_PEND, 8'h22);
    step(1);
    chk_int("p_int1", 1'b1);
    chk_rd("p_id1", A_ID, 8'h81);
    IRQ = 8'h00;
    wr(A_ACK, 8'h00);
    chk_rd("p_pend_mid", A_PEND, 8'h20);
    step(2);
    chk_int("p_hold2", 1'b0);
    chk_rd("p_pend_mid2", A_PEND, 8'h20);
    step(1);
    chk_int("p_int2", 1'b1);
    chk_rd("p_id2", A_ID, 8'h85);
    // Higher-priority edge during REQ must wait.
    IRQ = 8'h01;
    step(4);
    chk_rd("np_id", A_ID, 8'h85);
    chk_rd("np_pend", A_PEND, 8'h21);
    IRQ = 8'h00;
    wr(A_ACK, 8'h00);
    step(2);
    step(1);
    chk_rd("np_id0", A_ID, 8'h80);
    wr(A_ACK, 8'h00);
    chk_rd("np_pend_clr", A_PEND, 8'h00);
    step(3);

    // Masking: pending but masked source stays quiet until unmasked.
    wr(A_MASK, 8'h00);
    IRQ = 8'h01;
    step(3);
    chk_rd("m_pend", A_PEND, 8'h01);
    step(3);
    chk_int("m_int_masked", 1'b0);
    IRQ = 8'h00;
    wr(A_MASK, 8'h01);
    chk_int("m_int_edge1", 1'b0);
    step(1);
    chk_int("m_int_edge2", 1'b1);
    chk_rd("m_id", A_ID, 8'h80);
    // Mask cleared during REQ must not drop the request.
    wr(A_MASK, 8'h00);
    step(1);
    chk_int("m_mask_in_req", 1'b1);
    chk_rd("m_id_kept", A_ID, 8'h80);
    wr(A_ACK, 8'h00);
    step(3);

    // Collision: new IRQ[3] edge lands on the same edge as its ACK.
    wr(A_MASK, 8'h08);
    IRQ = 8'h08;
    step(4);
    chk_int("c_int1", 1'b1);
    chk_rd("c_id1", A_ID, 8'h83);
    IRQ = 8'h00;
    step(3);
    IRQ = 8'h08;
    step(2);
    wr(A_ACK, 8'h00);
    chk_rd("c_pend_kept", A_PEND, 8'h08);
    chk_int("c_hold0", 1'b0);
    step(2);
    chk_int("c_hold2", 1'b0);
    step(1);
    chk_int("c_int2", 1'b1);
    chk_rd("c_id2", A_ID, 8'h83);
    IRQ = 8'h00;
    wr(A_ACK, 8'h00);
    step(3);

    // Stray ACK in IDLE leaves a masked pending bit alone.
    wr(A_MASK, 8'h00);
    IRQ = 8'h40;
    step(3);
    IRQ = 8'h00;
    wr(A_ACK, 8'h00);
    chk_rd("sa_pend", A_PEND, 8'h40);
    chk_rd("sa_id", A_ID, 8'h03);
    chk_int("sa_int", 1'b0);

    // Reset mid-REQ: immediate clear, no retrigger.
    wr(A_MASK, 8'h02);
    IRQ = 8'h02;
    step(4);
    chk_int("r_int_req", 1'b1);
    IRQ = 8'h00;
    #2;
    RESET = 1'b1;
    #1;
    chk_int("r_int_async", 1'b0);
    chk_rd("r_mask_async", A_MASK, 8'h00);
    chk_rd("r_pend_async", A_PEND, 8'h00);
    step(1);
    RESET = 1'b0;
    step(6);
    chk_int("r_no_retrig", 1'b0);
    chk_rd("r_pend_after", A_PEND, 8'h00);

    // IRQ held high through reset release counts as one edge.
    IRQ = 8'h80;
    #2;
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    step(2);
    chk_rd("rh_pend_e1", A_PEND, 8'h00);
    step(1);
    chk_rd("rh_pend_e2", A_PEND, 8'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rat_int_ctrl.md
RAT_INT_CTRL -- requirements
Module: rat_int_ctrl

Interface
REQ-001 Parameter N_SRC, default 8: number of interrupt sources, fixed at 8 for this revision.
REQ-002 Parameter MASK_ADDR, default 8'hF0: read/write port for the enable mask.
REQ-003 Parameter ACK_ADDR, default 8'hF1: write-only end-of-interrupt port.
REQ-004 Parameter ID_ADDR, default 8'hF2: read-only port for the current-interrupt ID.
REQ-005 Parameter PEND_ADDR, default 8'hF3: read-only port for pending status.
REQ-006 CLK  in  1  single system clock; all state changes occur on its rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 IRQ  in  8  raw interrupt sources, asynchronous to CLK, rising-edge significant.
REQ-009 PORT_ID  in  8  CPU I/O address.
REQ-010 OUT_PORT  in  8  CPU output data.
REQ-011 IO_STRB  in  1  CPU output strobe, one cycle wide per OUT instruction.
REQ-012 INT_CU  out  1  registered interrupt request to the control unit.
REQ-013 IN_DATA  out  8  readback data for the CPU IN_PORT mux.
REQ-014 IN_SEL  out  1  combinational; high when PORT_ID equals MASK_ADDR, ID_ADDR or PEND_ADDR.

Function
REQ-015 Each IRQ bit SHALL pass through a two-flop synchronizer and then a rising-edge detector; a detected edge SHALL set PEND[i].
REQ-016 An edge on a bit that is already pending SHALL be absorbed; there is no edge counting.
REQ-017 When IO_STRB=1 and PORT_ID=MASK_ADDR, MASK SHALL load OUT_PORT at the next edge; MASK[i]=1 enables source i.
REQ-018 ACTIVE=PEND&MASK; priority SHALL be fixed, with the lowest index highest.
REQ-019 The FSM SHALL have three states: IDLE, REQ and HOLD; INT_CU SHALL be 1 only in REQ.
REQ-020 In IDLE with ACTIVE!=0, the FSM SHALL latch CUR_ID=the highest-priority index and go to REQ.
REQ-021 In REQ, an ACK_ADDR strobe SHALL clear PEND[CUR_ID], load the hold counter with 2 and go to HOLD; the write data is ignored.
REQ-022 In HOLD, the counter SHALL decrement each cycle and the FSM SHALL go to IDLE at 0, so INT_CU is low for at least 3 cycles between requests.
REQ-023 Latency: with IRQ high before edge E0, PEND SHALL set at E2 and INT_CU SHALL rise at E3, provided the FSM is IDLE and the source is unmasked.
REQ-024 A mask write during REQ SHALL NOT change CUR_ID or drop INT_CU; masking applies from the next IDLE decision onward.
REQ-025 ACK strobes in IDLE or HOLD SHALL be ignored.
REQ-026 If an edge on source CUR_ID coincides with its ACK clear, set SHALL win and the bit stays pending.
REQ-027 A higher-priority edge arriving during REQ SHALL NOT preempt; it is serviced after HOLD.
REQ-028 IN_DATA SHALL be combinational on PORT_ID:
 - MASK_ADDR: MASK
 - PEND_ADDR: PEND
 - ID_ADDR: {state==REQ, 4'b0, CUR_ID[2:0]}
 - any other address: 8'h00

Reset
REQ-029 RESET=1 SHALL immediately force the following, regardless of CLK:
 - state=IDLE, INT_CU=0
 - MASK=0, PEND=0, CUR_ID=0, hold counter=0
 - synchronizer and edge-history flops=0
REQ-030 An IRQ held high through reset release SHALL register as one edge.
REQ-031 Reset asserted during REQ SHALL discard the in-service request without a retrigger.

Structure
REQ-032 Package rat_int_pkg SHALL hold:
 - the state enum (IDLE, REQ, HOLD)
 - N_SRC
 - the default port addresses
 - the hold count constant (2)
REQ-033 Sub-module int_sync_edge (two-flop sync plus rising-edge detect, per-bit vector width) SHALL be instantiated once for the 8-bit IRQ bus.
REQ-034 The top level SHALL integrate by driving the control-unit INT_CU from this block and muxing IN_DATA onto IN_PORT when IN_SEL=1.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
 - Single source: MASK=8'h04, pulse IRQ[2] -> INT_CU rises 3 edges after sample; read ID_ADDR=8'h82; write ACK -> PEND=8'h00, INT_CU low for 3 cycles.
 - Priority: MASK=8'hFF, IRQ[5] and IRQ[1] rise together -> CUR_ID=1 first; after ACK+HOLD -> CUR_ID=5; PEND reads 8'h20 between the two.
 - Masking: MASK=8'h00, pulse IRQ[0] -> PEND=8'h01, INT_CU stays 0; write MASK=8'h01 -> INT_CU rises 2 edges later.
 - Collision: IRQ[3] edge detected in the same cycle as the ACK for CUR_ID=3 -> PEND[3] remains 1, second request follows HOLD.
 - Stray ACK and reset: ACK in IDLE -> no state change; RESET mid-REQ -> INT_CU=0 and MASK=0 immediately, no request after release with IRQ low.
